pll_lock_sequencer: RTL and testbench

//  Power-up and lock supervisor for the two-output system PLL (100/50 MHz from 50 MHz refclk).

---
 rtl/pll_lock_sequencer_if.sv | 37 +++
 rtl/pll_lock_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if
//   Groups the PLL lock sequencer's status/control signals.
//   master : the sequencer (samples pll_locked/relock_req, drives the rest)
//   slave  : the surrounding system / PLL wrapper
//   Signals:
//     pll_locked  PLL locked flag (asynchronous to refclk)
//     relock_req  single-cycle restart request
//     pll_rst     PLL reset, active-high
//     sys_rst     downstream reset, active-high
//     ready       high only in RUN
//     fault       high only in FAULT
//     retry_cnt   failed attempts since last RUN/FAULT exit
//     state       encoded FSM state for debug
//     loss_cnt    RUN exits caused by lock loss (only with PLL_SEQ_LOSS_CNT_EN)
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [2:0] state;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  modport master (input pll_locked, relock_req,
                  output pll_rst, sys_rst, ready, fault, retry_cnt, state, loss_cnt);
  modport slave  (output pll_locked, relock_req,
                  input pll_rst, sys_rst, ready, fault, retry_cnt, state, loss_cnt);
`else
  modport master (input pll_locked, relock_req,
                  output pll_rst, sys_rst, ready, fault, retry_cnt, state);
  modport slave  (output pll_locked, relock_req,
                  input pll_rst, sys_rst, ready, fault, retry_cnt, state);
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Power-up and lock supervisor for the system PLL. Pulses the PLL reset,
//   waits for a synchronized lock flag to hold steady, then releases the
//   downstream reset. Lock loss restarts the sequence; repeated lock
//   timeouts park the block in a sticky FAULT state until relock_req or rst.
//   Ports:
//     refclk  free-running reference clock (only clock)
//     rst     asynchronous active-high reset
//     bus     pll_lock_sequencer_if.master (see interface header)
//   Optional feature: define PLL_SEQ_LOSS_CNT_EN to add the saturating
//   loss_cnt output (RUN exits caused by lock loss).
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 17
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_lock_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [7:0]       RETRY_LAST   = 8'(MAX_RETRIES - 1);
  localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       retry_q;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, sys_rst_q, ready_q, fault_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0]       loss_q;
`endif

  // Two-flop synchronizer for the asynchronous locked flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Main FSM. Every output is registered and updated on the same edge as
  // the state, so outputs always agree with the visible state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_q    <= '0;
`endif
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == PULSE_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout landing on the same cycle.
          if (locked_s_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q == RETRY_LAST) begin
              state_q <= FAULT;
              retry_q <= RETRY_MAX;
              fault_q <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
              retry_q <= retry_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STABLE: begin
          // A glitch restarts the timeout window without costing a retry.
          if (!locked_s_q) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            retry_q   <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s_q || bus.relock_req) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
            if (!locked_s_q && loss_q != 8'hFF) loss_q <= loss_q + 1'b1;
`endif
          end
        end
        FAULT: begin
          if (bus.relock_req) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= RESET_PLL;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  assign bus.loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;
  localparam int RST_P = 4;
  localparam int STB_P = 8;
  localparam int TO_P  = 32;
  localparam int MAX_P = 2;

  logic refclk = 1'b0;
  logic rst;
  always #10 refclk = ~refclk;

  pll_lock_sequencer_if pif();

  pll_lock_sequencer #(
    .RST_PULSE_CYC(RST_P), .LOCK_STABLE_CYC(STB_P), .LOCK_TIMEOUT_CYC(TO_P),
    .MAX_RETRIES(MAX_P), .CNT_W(6)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (pif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: phases are tracked by the edge count at which they
  // were entered, and the synchronizer by the history of sampled inputs.
  int now, t0, ph, retry, loss;
  logic h1, h2;

  task automatic m_reset();
    ph = 0; t0 = now; retry = 0; loss = 0; h1 = 1'b0; h2 = 1'b0;
  endtask

  task automatic go(input int p);
    ph = p; t0 = now;
  endtask

  task automatic m_step(input logic lk, input logic rq);
    logic ls;
    int   el;
    now++;
    ls = h2; h2 = h1; h1 = lk;
    el = now - t0;
    case (ph)
      0: if (el == RST_P) go(1);
      1: if (ls) go(2);
         else if (el == TO_P) begin
           if (retry == MAX_P - 1) begin retry = MAX_P; go(4); end
           else begin retry++; go(0); end
         end
      2: if (!ls) go(1);
         else if (el == STB_P) begin retry = 0; go(3); end
      3: if (!ls || rq) begin
           if (!ls && loss < 255) loss++;
           go(0);
         end
      default: if (rq) begin retry = 0; go(0); end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(pif.state),     32'(ph));
    chk({tag, ".pll_rst"}, 32'(pif.pll_rst),   32'(ph == 0 || ph == 4));
    chk({tag, ".sys_rst"}, 32'(pif.sys_rst),   32'(ph != 3));
    chk({tag, ".ready"},   32'(pif.ready),     32'(ph == 3));
    chk({tag, ".fault"},   32'(pif.fault),     32'(ph == 4));
    chk({tag, ".retry"},   32'(pif.retry_cnt), 32'(retry));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk({tag, ".loss"},    32'(pif.loss_cnt),  32'(loss));
`endif
  endtask

  int   seg;
  logic lvl;

  initial begin
    now = 0; seg = 0; lvl = 1'b0;
    rst = 1'b1;
    pif.pll_locked = 1'b0;
    pif.relock_req = 1'b0;
    m_reset();
    repeat (3) @(posedge refclk);
    #1 check_all("reset");
    @(negedge refclk);
    rst = 1'b0;
    m_reset();

    for (int i = 0; i < 4000; i++) begin
      // Segmented lock waveform: long lows reach timeouts/FAULT, long highs
      // reach RUN, very short segments exercise glitch handling.
      if (seg == 0) begin
        lvl = 1'($urandom_range(0, 1));
        if (lvl) seg = $urandom_range(1, 50);
        else if ($urandom_range(0, 3) == 0) seg = $urandom_range(60, 150);
        else seg = $urandom_range(1, 20);
      end
      seg--;
      pif.pll_locked = lvl;
      pif.relock_req = ($urandom_range(0, 29) == 0);
      @(posedge refclk);
      m_step(pif.pll_locked, pif.relock_req);
      #1 check_all("cycle");
      if ($urandom_range(0, 299) == 0) begin
        // Asynchronous reset in the middle of a cycle.
        #2 rst = 1'b1;
        #1 m_reset();
        check_all("async_rst");
        @(negedge refclk);
        rst = 1'b0;
      end else begin
        @(negedge refclk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
